mem_stage_lsu: RTL and testbench

Load/store unit for the MEM stage of the RV32IM pipeline. It sits between the EX/MEM register and the MEM/WB register. It turns EX/MEM load/store requests into req/ack transactions on the data-memory bus, generating byte enables and store-data replication. It aligns and sign/zero-extends load data into the mem_data_in input of MEM/WB, and stalls the pipeline while a bus transaction is outstanding.

---
 rtl/mem_stage_lsu.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store requests into req/ack data-bus
// transactions, extends returned load data and stalls the pipeline while a transfer is outstanding.
module mem_stage_lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        fault,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam bit             WDOG_EN  = (TIMEOUT != 32'sd0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

    state_t            state_r;
    state_t            state_nx_s;
    logic              req_r;
    logic              we_r;
    logic [31:0]       addr_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [31:0]       load_data_r;
    logic              done_r;
    logic              bus_err_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        off_r;
    logic [2:0]        f3_r;

    logic              access_s;
    logic              illegal_s;
    logic              misalign_s;
    logic              fault_s;
    logic              start_s;
    logic              timeout_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;

    // Byte lane selection and sign/zero extension of the returned word.
    function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  extract_load = {{24{sh[7]}}, sh[7:0]};
            3'b001:  extract_load = {{16{sh[15]}}, sh[15:0]};
            3'b100:  extract_load = {24'h000000, sh[7:0]};
            3'b101:  extract_load = {16'h0000, sh[15:0]};
            default: extract_load = sh;
        endcase
    endfunction

    // Decode legality, alignment, byte enables and store-data replication.
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        be_s       = 4'h0;
        wdata_s    = 32'h0000_0000;
        if (mem_read) begin
            be_s = 4'hF;
            case (funct3)
                3'b000, 3'b100: misalign_s = 1'b0;
                3'b001, 3'b101: misalign_s = addr[0];
                3'b010:         misalign_s = (addr[1:0] != 2'b00);
                default:        illegal_s  = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000: begin
                    be_s    = 4'b0001 << addr[1:0];
                    wdata_s = {4{store_data[7:0]}};
                end
                3'b001: begin
                    misalign_s = addr[0];
                    be_s       = 4'b0011 << addr[1:0];
                    wdata_s    = {2{store_data[15:0]}};
                end
                3'b010: begin
                    misalign_s = (addr[1:0] != 2'b00);
                    be_s       = 4'hF;
                    wdata_s    = store_data;
                end
                default: illegal_s = 1'b1;
            endcase
        end
    end

    assign access_s  = (state_r == S_IDLE) & ex_valid & (mem_read | mem_write);
    assign fault_s   = access_s & (illegal_s | misalign_s);
    assign start_s   = access_s & ~(illegal_s | misalign_s);
    assign timeout_s = WDOG_EN & (cnt_r == CNT_LAST);

    // Next-state selection.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_nx_s = S_WAIT;
                else         state_nx_s = S_IDLE;
            end
            S_WAIT: begin
                if (dmem_ack || timeout_s) state_nx_s = S_RESP;
                else                       state_nx_s = S_WAIT;
            end
            S_RESP:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State, bus outputs, watchdog and load result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            be_r        <= 4'h0;
            wdata_r     <= 32'h0000_0000;
            load_data_r <= 32'h0000_0000;
            done_r      <= 1'b0;
            bus_err_r   <= 1'b0;
            cnt_r       <= '0;
            off_r       <= 2'b00;
            f3_r        <= 3'b000;
        end else begin
            state_r   <= state_nx_s;
            done_r    <= 1'b0;
            bus_err_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        req_r   <= 1'b1;
                        we_r    <= mem_write & ~mem_read;
                        addr_r  <= {addr[31:2], 2'b00};
                        be_r    <= be_s;
                        wdata_r <= wdata_s;
                        cnt_r   <= '0;
                        off_r   <= addr[1:0];
                        f3_r    <= funct3;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        req_r  <= 1'b0;
                        we_r   <= 1'b0;
                        done_r <= 1'b1;
                        if (!we_r) load_data_r <= extract_load(dmem_rdata, off_r, f3_r);
                    end else if (timeout_s) begin
                        req_r       <= 1'b0;
                        we_r        <= 1'b0;
                        done_r      <= 1'b1;
                        bus_err_r   <= 1'b1;
                        load_data_r <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req   = req_r;
    assign dmem_we    = we_r;
    assign dmem_addr  = addr_r;
    assign dmem_be    = be_r;
    assign dmem_wdata = wdata_r;
    assign load_data  = load_data_r;
    assign done       = done_r;
    assign bus_err    = bus_err_r;
    assign fault      = fault_s;
    assign stall      = start_s | (state_r == S_WAIT);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu; completions are checked by a scoreboard monitor.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, done, fault, bus_err;
    logic [31:0] load_data;

    typedef struct packed {
        logic [31:0] ld;
        logic        berr;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_ld = 32'h0;

    mem_stage_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .load_data(load_data), .done(done), .fault(fault), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1, expected no completion");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_load_data", load_data, e.ld);
                chk("sb_bus_err", {31'd0, bus_err}, {31'd0, e.berr});
            end
        end
    end

    task automatic drive_idle();
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    // Complete access; entered and left at posedge+1 of an IDLE cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input int ack_delay, input logic [31:0] rdata,
                             input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic [31:0] e_wdata, input logic [31:0] e_ld);
        ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = sd;
        sb_q.push_back('{ld: e_ld, berr: 1'b0});
        last_ld = e_ld;
        @(negedge clk);
        chk("start_stall", {31'd0, stall}, 32'd1);
        chk("start_fault", {31'd0, fault}, 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            chk("wait_req", {31'd0, dmem_req}, 32'd1);
            @(posedge clk); #1;
        end
        dmem_ack = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        chk("bus_req", {31'd0, dmem_req}, 32'd1);
        chk("bus_we", {31'd0, dmem_we}, {31'd0, wr & ~rd});
        chk("bus_addr", dmem_addr, e_addr);
        chk("bus_be", {28'd0, dmem_be}, {28'd0, e_be});
        chk("bus_wdata", dmem_wdata, e_wdata);
        chk("wait_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        chk("resp_stall", {31'd0, stall}, 32'd0);
        chk("resp_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_fault(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a);
        ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
        @(negedge clk);
        chk("fault_pulse", {31'd0, fault}, 32'd1);
        chk("fault_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("fault_no_req", {31'd0, dmem_req}, 32'd0);
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n_req;
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_be", {28'd0, dmem_be}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // rd wr f3 addr sdata delay rdata e_addr e_be e_wdata e_ld
        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h80112233, 32'h100, 4'hF, 32'h0, 32'h00000080);
        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80112233, 32'h100, 4'hF, 32'h0, 32'hFFFF8011);
        do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h80112233, 32'h100, 4'hF, 32'h0, 32'h00008011);
        do_access(1'b1, 1'b1, 3'b000, 32'h101, 32'h0, 0, 32'h80112233, 32'h100, 4'hF, 32'h0, 32'h00000022);
        do_access(1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, 0, 32'hFFFFFFFF, 32'h204, 4'b1100, 32'hABCDABCD, last_ld);
        do_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000005A, 0, 32'hFFFFFFFF, 32'h200, 4'b0010, 32'h5A5A5A5A, last_ld);
        do_access(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0, 32'h300, 4'hF, 32'hCAFEF00D, last_ld);

        do_fault(1'b1, 1'b0, 3'b010, 32'h102);
        do_fault(1'b1, 1'b0, 3'b011, 32'h100);
        do_fault(1'b0, 1'b1, 3'b001, 32'h203);

        // Watchdog: ack withheld.
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h400;
        sb_q.push_back('{ld: 32'h0, berr: 1'b1});
        @(posedge clk); #1;
        ex_valid = 1'b0;
        n_req = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dmem_req) n_req++;
        end
        chk("timeout_req_cycles", n_req, 32'd16);
        chk("timeout_stall", {31'd0, stall}, 32'd0);
        chk("timeout_load_data", load_data, 32'h0);
        @(posedge clk); #1;

        // Reset in the third WAIT cycle, late ack afterwards.
        do_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 0, 32'h13572468, 32'h500, 4'hF, 32'h0, 32'h13572468);
        ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h600;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst_addr", dmem_addr, 32'h0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("midrst_load_data", load_data, 32'h0);
        chk("midrst_req_after_ack", {31'd0, dmem_req}, 32'd0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
